sar_signed_search: RTL and testbench

- Successive-approximation controller that is the initiator side of a signed greater-or-equal comparator.
- It drives a signed trial value to an external comparator (GE = X >= TRIAL, two's complement) and reads back the GE bit.
- It binary-searches for the largest TRIAL with GE=1, which equals X.
- Used for threshold search, ADC-style conversion and signed calibration loops on iCE40 designs.

---
 rtl/sar_pkg.sv | 27 ++
 rtl/sar_settle_timer.sv | 41 ++++
 rtl/sar_signed_search.sv | 110 +++++++++++
 tb/tb_sar_signed_search.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sar_pkg : shared FSM encoding and helpers for the signed SAR search  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sar_pkg;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_test = 1'b1;

  localparam int c_max_w = 64;

  // Settle counter must hold CMP_LAT; never narrower than one bit.
  function automatic int wait_cnt_w(input int cmp_lat);
    return (cmp_lat < 1) ? 1 : $clog2(cmp_lat + 1);
  endfunction

  // Offset-binary to two's complement is an MSB flip at bit (width-1).
  function automatic logic [c_max_w-1:0] offset_to_signed(
    input logic [c_max_w-1:0] u,
    input int                 width
  );
    return u ^ (c_max_w'(1) << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sar_settle_timer : loadable down-counter flagging comparator settle  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sar_settle_timer
  import sar_pkg::*;
#(
  parameter int CMP_LAT = 0
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_load,
  output logic o_zero
);

  generate
    if (CMP_LAT == 0) begin : g_comb
      logic w_unused;
      assign w_unused = &{1'b0, i_clk, i_resetn, i_load};
      assign o_zero   = 1'b1;
    end else begin : g_count
      localparam int c_cw = wait_cnt_w(CMP_LAT);
      logic [c_cw-1:0] r_cnt;

      always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
          r_cnt <= '0;
        end else if (i_load) begin
          r_cnt <= c_cw'(CMP_LAT);
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - c_cw'(1);
        end
      end

      assign o_zero = (r_cnt == '0);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sar_signed_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sar_signed_search : SAR initiator for a signed X >= TRIAL comparator |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sar_signed_search
  import sar_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 0
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_ge,
  output logic [WIDTH-1:0] o_trial,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy,
  output logic             o_done
);

  localparam int c_iw = $clog2(WIDTH);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] r_result;
  logic [c_iw-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_u_dec;
  logic [WIDTH-1:0] w_sgn_dec;
  logic             w_last;
  logic             w_decide;
  logic             w_load;
  logic             w_wait_zero;

  // Clear the bit under test on GE=0 and arm the next one in the same edge.
  always_comb begin
    w_u_dec = r_u;
    if (!i_ge) w_u_dec[r_idx] = 1'b0;
    if (!w_last) w_u_dec[r_idx - c_iw'(1)] = 1'b1;
  end

  assign w_sgn_dec = WIDTH'(offset_to_signed(c_max_w'(w_u_dec), WIDTH));
  assign w_last    = (r_idx == '0);
  assign w_decide  = (r_state == c_st_test) && !i_abort && w_wait_zero;
  assign w_load    = ((r_state == c_st_idle) && i_start) || (w_decide && !w_last);

  sar_settle_timer #(
    .CMP_LAT (CMP_LAT)
  ) u_timer (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_load   (w_load),
    .o_zero   (w_wait_zero)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= c_st_idle;
      r_u      <= '0;
      r_trial  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (i_start) begin
            r_u     <= {1'b1, {(WIDTH-1){1'b0}}};
            r_trial <= '0;
            r_idx   <= c_iw'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_state <= c_st_test;
          end
        end
        c_st_test: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= c_st_idle;
          end else if (w_wait_zero) begin
            r_u     <= w_u_dec;
            r_trial <= w_sgn_dec;
            if (w_last) begin
              r_result <= w_sgn_dec;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= c_st_idle;
            end else begin
              r_idx <= r_idx - c_iw'(1);
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign o_trial  = r_trial;
  assign o_result = r_result;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sar_signed_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sar_signed_search : scoreboard bench, CMP_LAT=0 and CMP_LAT=2     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sar_signed_search;

  localparam int W    = 8;
  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n [2];
  logic               start [2];
  logic               abort [2];
  logic               ge    [2];
  logic               busy  [2];
  logic               done  [2];
  logic signed [W-1:0] trial [2];
  logic signed [W-1:0] result[2];
  logic signed [W-1:0] x     [2];
  logic signed [W-1:0] d1_a, d1_b;
  logic               noise;

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t q0[$];
  exp_t q1[$];

  int s37 [8] = '{0, 64, 32, 48, 40, 36, 38, 37};
  int s128[8] = '{0, -64, -96, -112, -120, -124, -126, -127};
  int tab0[9] = '{0, 1, -2, 127, -128, 85, -86, 64, -65};
  int tab1[6] = '{37, -1, 0, -37, 100, -100};

  sar_signed_search #(.WIDTH(W), .CMP_LAT(LAT0)) u_dut0 (
    .i_clk(clk), .i_resetn(rst_n[0]), .i_start(start[0]), .i_abort(abort[0]),
    .i_ge(ge[0]), .o_trial(trial[0]), .o_result(result[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  sar_signed_search #(.WIDTH(W), .CMP_LAT(LAT1)) u_dut1 (
    .i_clk(clk), .i_resetn(rst_n[1]), .i_start(start[1]), .i_abort(abort[1]),
    .i_ge(ge[1]), .o_trial(trial[1]), .o_result(result[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  // Comparators: instance 1 sees TRIAL two cycles late and returns noise until settled.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    d1_a  <= trial[1];
    d1_b  <= d1_a;
    noise <= 1'($urandom_range(0, 1));
  end

  always_comb begin
    ge[0] = (x[0] >= trial[0]);
    ge[1] = (d1_b == trial[1]) ? (x[1] >= d1_b) : noise;
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic push(input int i, input int r);
    exp_t e;
    e.res = r;
    e.cyc = cyc;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic launch(input int i, input int xv, input bit do_push);
    x[i]     = W'(xv);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    if (do_push) push(i, xv);
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (done[i] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen%0d", i), int'(done[i]), 1);
  endtask

  // Monitor: every DONE pops one expectation and checks value and latency.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst_n[i] === 1'b1 && done[i] === 1'b1) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done%0d: got DONE=1, expected no pending search", i);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("result%0d", i), int'(result[i]), e.res);
          chk($sformatf("latency%0d", i), cyc - e.cyc, W * (((i == 0) ? LAT0 : LAT1) + 1));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int c_first;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      abort[i] = 1'b0;
      x[i]     = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_trial",  int'(trial[i]),  0);
      chk("rst_result", int'(result[i]), 0);
      chk("rst_busy",   int'(busy[i]),   0);
      chk("rst_done",   int'(done[i]),   0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // X=37, combinational comparator: TRIAL walk and BUSY window
    launch(0, 37, 1);
    for (int k = 0; k < 8; k++) begin
      chk("trial37", int'(trial[0]), s37[k]);
      chk("busy37",  int'(busy[0]),  1);
      @(negedge clk);
    end
    chk("busy37_end", int'(busy[0]), 0);
    chk("done37",     int'(done[0]), 1);
    @(negedge clk);

    // Back-to-back: START in the DONE cycle
    launch(0, -1, 1);
    wait_done(0);
    c_first  = cyc;
    x[0]     = 8'sd5;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    push(0, 5);
    wait_done(0);
    chk("b2b_spacing", cyc - c_first, 9);
    @(negedge clk);

    // ABORT sampled on edge 4 of a search
    launch(0, 20, 0);
    repeat (3) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_busy",   int'(busy[0]),   0);
    chk("abort_result", int'(result[0]), 5);
    repeat (12) @(negedge clk);
    chk("abort_hold",   int'(result[0]), 5);

    // START and ABORT together in IDLE, then a START while BUSY
    x[0]     = -8'sd77;
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    push(0, -77);
    chk("start_wins", int'(busy[0]), 1);
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    @(negedge clk);

    // Asynchronous reset mid-search
    launch(0, 100, 0);
    repeat (2) @(negedge clk);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("arst_trial",  int'(trial[0]),  0);
    chk("arst_result", int'(result[0]), 0);
    chk("arst_busy",   int'(busy[0]),   0);
    chk("arst_done",   int'(done[0]),   0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    launch(0, -50, 1);
    wait_done(0);
    @(negedge clk);

    foreach (tab0[j]) begin
      launch(0, tab0[j], 1);
      wait_done(0);
      @(negedge clk);
    end

    // CMP_LAT=2, X=-128: each TRIAL held three cycles
    launch(1, -128, 1);
    for (int k = 0; k < 24; k++) begin
      chk("trial_m128", int'(trial[1]), s128[k / 3]);
      @(negedge clk);
    end
    chk("done_m128", int'(done[1]), 1);
    @(negedge clk);

    launch(1, 127, 1);
    wait_done(1);
    @(negedge clk);

    // ABORT on the final decision edge leaves RESULT untouched
    launch(1, 9, 0);
    repeat (23) @(negedge clk);
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    chk("abort_last_busy",   int'(busy[1]),   0);
    chk("abort_last_result", int'(result[1]), 127);
    repeat (5) @(negedge clk);

    foreach (tab1[j]) begin
      launch(1, tab1[j], 1);
      wait_done(1);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
